// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by instruction_fetch and controller.
//   ADDR_W / INSTR_W : default instruction address and instruction widths
//   *_MSB / *_LSB    : bit positions of the opcode and function fields in an instruction
//   fetch_state_e    : fetch-stage state encoding
package cpu_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned INSTR_W = 19;

  // Opcode fields.
  localparam int unsigned OP2_MSB = 18;
  localparam int unsigned OP2_LSB = 17;
  localparam int unsigned OP3_MSB = 18;
  localparam int unsigned OP3_LSB = 16;

  // Function fields.
  localparam int unsigned FN3_MSB = 16;
  localparam int unsigned FN3_LSB = 14;
  localparam int unsigned FN2_MSB = 15;
  localparam int unsigned FN2_LSB = 14;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: requests instructions over a req/ack handshake, holds the word in the IR and
// exposes its opcode/function fields to the controller.
//   clock, rst (async, active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   ir_valid/ir_ready                      : IR handshake towards the controller
//   ir, ir_pc                              : instruction register and its address
//   lasttwoBits, lastthreeBits,
//   threeBitFn, twoBitFn                   : field slices of ir
//   redirect/redirect_pc                   : taken branch/jump
//   pc                                     : next address to fetch
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic [1:0]         lasttwoBits,
  output logic [2:0]         lastthreeBits,
  output logic [2:0]         threeBitFn,
  output logic [1:0]         twoBitFn,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc
);

  typedef cpu_pkg::fetch_state_e state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               ir_valid_q;

  logic [ADDR_W-1:0]  pc_inc;

  assign pc_inc = pc_q + ADDR_W'(1);

  // In HOLD a request is raised only in the cycle the controller drains the IR, which is what
  // allows one instruction per cycle with a zero-wait memory.
  assign imem_req = (state_q == cpu_pkg::StFetch) || (state_q == cpu_pkg::StDrain) ||
                    ((state_q == cpu_pkg::StHold) && ir_ready && !redirect);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= cpu_pkg::StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        cpu_pkg::StIdle: begin
          req_addr_q <= pc_q;
          state_q    <= cpu_pkg::StFetch;
        end
        cpu_pkg::StFetch: begin
          if (redirect) begin
            pc_q <= redirect_pc;
            if (imem_ack) begin
              // Data returned for the old path is dropped; restart at the target at once.
              req_addr_q <= redirect_pc;
            end else begin
              // Old request must complete at its original address before the target is sent.
              state_q <= cpu_pkg::StDrain;
            end
          end else if (imem_ack) begin
            ir_q       <= imem_rdata;
            ir_pc_q    <= req_addr_q;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_inc;
            req_addr_q <= pc_inc;
            state_q    <= cpu_pkg::StHold;
          end
        end
        cpu_pkg::StHold: begin
          if (redirect) begin
            ir_valid_q <= 1'b0;
            pc_q       <= redirect_pc;
            req_addr_q <= redirect_pc;
            state_q    <= cpu_pkg::StFetch;
          end else if (ir_ready) begin
            if (imem_ack) begin
              ir_q       <= imem_rdata;
              ir_pc_q    <= req_addr_q;
              pc_q       <= pc_inc;
              req_addr_q <= pc_inc;
            end else begin
              // Request already went out at req_addr_q == pc_q; keep it in FETCH.
              ir_valid_q <= 1'b0;
              state_q    <= cpu_pkg::StFetch;
            end
          end
        end
        cpu_pkg::StDrain: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end
          if (imem_ack) begin
            req_addr_q <= redirect ? redirect_pc : pc_q;
            state_q    <= cpu_pkg::StFetch;
          end
        end
        default: state_q <= cpu_pkg::StIdle;
      endcase
    end
  end

  assign imem_addr     = req_addr_q;
  assign ir_valid      = ir_valid_q;
  assign ir            = ir_q;
  assign ir_pc         = ir_pc_q;
  assign pc            = pc_q;
  assign lasttwoBits   = ir_q[cpu_pkg::OP2_MSB:cpu_pkg::OP2_LSB];
  assign lastthreeBits = ir_q[cpu_pkg::OP3_MSB:cpu_pkg::OP3_LSB];
  assign threeBitFn    = ir_q[cpu_pkg::FN3_MSB:cpu_pkg::FN3_LSB];
  assign twoBitFn      = ir_q[cpu_pkg::FN2_MSB:cpu_pkg::FN2_LSB];

endmodule
